// File: rtl/noc_pkg.sv
// Shared NoC helpers: default item width, index-width function and round-robin wrap arithmetic.
package noc_pkg;

    localparam int ITEM_W = 8;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Explicit compare-and-subtract keeps non-power-of-two port counts free of a modulo.
    function automatic int rr_next(input int g, input int ports);
        return (g == ports - 1) ? 0 : g + 1;
    endfunction

    function automatic int rr_offset(input int base, input int off, input int ports);
        int s;
        s = base + off;
        return (s >= ports) ? s - ports : s;
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; rotate requests to start at ptr,
// priority-encode the lowest set bit, then un-rotate the offset back to a port index.
module rr_pick
    import noc_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int IDXW  = clog2(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [IDXW-1:0]  ptr,
    output logic             grant_valid,
    output logic [IDXW-1:0]  grant
);

    logic [PORTS-1:0] rot;
    logic [IDXW-1:0]  offs;

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rot         = '0;
        grant_valid = 1'b0;
        offs        = '0;
        for (int j = 0; j < PORTS; j++) begin
            rot[j] = req[IDXW'(rr_offset(int'(ptr), j, PORTS))];
        end
        for (int j = PORTS - 1; j >= 0; j--) begin
            if (rot[j]) begin
                grant_valid = 1'b1;
                offs        = IDXW'(j);
            end
        end
        grant = IDXW'(rr_offset(int'(ptr), int'(offs), PORTS));
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin pop of PORTS input FIFOs into a registered valid/ready output.
// Build option ARB_SKID_EN adds a one-entry skid register and removes the out_ready -> read path.
module fifo_rr_arbiter
    import noc_pkg::*;
#(
    parameter  int ID    = -1,
    parameter  int SIZE  = ITEM_W,
    parameter  int PORTS = 4,
    localparam int IDXW  = clog2(PORTS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PORTS-1:0]      empty,
    input  logic [PORTS*SIZE-1:0] item_in,
    output logic [PORTS-1:0]      read,
    output logic [SIZE-1:0]       item_out,
    output logic [IDXW-1:0]       out_src,
    output logic                  out_valid,
    input  logic                  out_ready
);

    if (PORTS < 2 || PORTS > 16) begin : g_bad_ports
        $error("fifo_rr_arbiter %0d: PORTS=%0d outside 2..16", ID, PORTS);
    end

    logic            grant_valid;
    logic [IDXW-1:0] grant;
    logic [SIZE-1:0] grant_item;
    logic            load;
    logic            accept;

    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [SIZE-1:0] item_q, item_d;
    logic [IDXW-1:0] src_q, src_d;
    logic            valid_q, valid_d;

    rr_pick #(.PORTS(PORTS), .IDXW(IDXW)) u_pick (
        .req         (~empty),
        .ptr         (ptr_q),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_comb begin
        grant_item = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (grant == IDXW'(i)) grant_item = item_in[i*SIZE +: SIZE];
        end
    end

    assign accept = valid_q && out_ready;

`ifdef ARB_SKID_EN
    logic            skid_valid_q, skid_valid_d;
    logic [SIZE-1:0] skid_item_q, skid_item_d;
    logic [IDXW-1:0] skid_src_q, skid_src_d;

    assign load = grant_valid && !skid_valid_q && !reset;

    always_comb begin
        item_d       = item_q;
        src_d        = src_q;
        valid_d      = valid_q;
        skid_item_d  = skid_item_q;
        skid_src_d   = skid_src_q;
        skid_valid_d = skid_valid_q;
        if (accept) begin
            // A held skid entry is older than anything granted now, so it drains first.
            if (skid_valid_q) begin
                item_d       = skid_item_q;
                src_d        = skid_src_q;
                skid_valid_d = 1'b0;
            end else if (load) begin
                item_d = grant_item;
                src_d  = grant;
            end else begin
                valid_d = 1'b0;
            end
        end else if (!valid_q) begin
            if (load) begin
                item_d  = grant_item;
                src_d   = grant;
                valid_d = 1'b1;
            end
        end else if (load) begin
            skid_item_d  = grant_item;
            skid_src_d   = grant;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            skid_valid_q <= 1'b0;
            skid_item_q  <= '0;
            skid_src_q   <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_item_q  <= skid_item_d;
            skid_src_q   <= skid_src_d;
        end
    end
`else
    assign load = grant_valid && (!valid_q || out_ready) && !reset;

    always_comb begin
        item_d  = item_q;
        src_d   = src_q;
        valid_d = valid_q;
        if (load) begin
            item_d  = grant_item;
            src_d   = grant;
            valid_d = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end
`endif

    // Priority only rotates on a pop, so a stalled output keeps the current order.
    assign ptr_d = load ? IDXW'(rr_next(int'(grant), PORTS)) : ptr_q;

    always_comb begin
        read = '0;
        if (load) read[grant] = 1'b1;
    end

    // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            item_q  <= '0;
            src_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            item_q  <= item_d;
            src_q   <= src_d;
            valid_q <= valid_d;
        end
    end

    assign item_out  = item_q;
    assign out_src   = src_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: queue-based FIFOs and a transaction-level model
// checked every cycle, plus literal expectations for each scenario.
module tb_fifo_rr_arbiter;

    localparam int PORTS = 4;
    localparam int SIZE  = 8;
`ifdef ARB_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic [PORTS-1:0]      empty;
    logic [PORTS*SIZE-1:0] item_in;
    logic [PORTS-1:0]      read;
    logic [SIZE-1:0]       item_out;
    logic [1:0]            out_src;
    logic                  out_valid;
    logic                  out_ready;

    always #5 clk = ~clk;

    fifo_rr_arbiter #(.ID(0), .SIZE(SIZE), .PORTS(PORTS)) dut (
        .clk       (clk),
        .reset     (reset),
        .empty     (empty),
        .item_in   (item_in),
        .read      (read),
        .item_out  (item_out),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [7:0] item;
        logic [1:0] src;
    } ent_t;

    bq_t        fq[PORTS];
    ent_t       pipe[$];
    int         m_ptr;
    logic [7:0] shown_item;
    logic [1:0] shown_src;
    int         n_cmp  = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_grant();
        for (int k = 0; k < PORTS; k++) begin
            if (fq[(m_ptr + k) % PORTS].size() != 0) return (m_ptr + k) % PORTS;
        end
        return -1;
    endfunction

    // Items in flight may be at most CAP; without skid a full register can still refill on accept.
    function automatic bit m_load();
        if (reset || m_grant() < 0) return 1'b0;
        if (CAP == 1) return pipe.size() == 0 || out_ready;
        return pipe.size() < CAP;
    endfunction

    function automatic logic [3:0] m_read();
        return m_load() ? 4'(1 << m_grant()) : 4'b0000;
    endfunction

    task automatic compare();
        check("read", read, m_read());
        check("out_valid", out_valid, pipe.size() > 0);
        check("item_out", item_out, shown_item);
        check("out_src", out_src, shown_src);
    endtask

    task automatic model_update();
        int         g;
        bit         ld;
        logic [7:0] v;
        if (reset) begin
            pipe.delete();
            m_ptr      = 0;
            shown_item = '0;
            shown_src  = '0;
        end else begin
            g  = m_grant();
            ld = m_load();
            if (pipe.size() > 0 && out_ready) void'(pipe.pop_front());
            if (ld) begin
                v = fq[g].pop_front();
                pipe.push_back('{item: v, src: 2'(g)});
                m_ptr = (g + 1) % PORTS;
            end
            if (pipe.size() > 0) begin
                shown_item = pipe[0].item;
                shown_src  = pipe[0].src;
            end
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < PORTS; i++) begin
            empty[i]                = (fq[i].size() == 0);
            item_in[i*SIZE +: SIZE] = (fq[i].size() != 0) ? fq[i][0] : 8'h00;
        end
    endtask

    task automatic push(input int i, input logic [7:0] v);
        fq[i].push_back(v);
        refresh();
    endtask

    task automatic neg();
        @(negedge clk);
        compare();
    endtask

    task automatic pos();
        @(posedge clk);
        model_update();
        #1;
        refresh();
    endtask

    task automatic step(input int n);
        repeat (n) begin
            neg();
            pos();
        end
    endtask

    initial begin
        int         t2_src[5]  = '{0, 1, 2, 3, 0};
        int         t2_item[5] = '{'h01, 'h11, 'h21, 'h31, 'h02};
        int         t3_item[3] = '{'h11, 'h22, 'h33};
        int         t3_read[3] = '{'b0100, 'b0100, 'b0000};
        int         nreads;

        reset     = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            for (int k = 0; k < 2; k++) push(i, 8'(i * 16 + k + 1));
        end
        @(posedge clk);
        model_update();
        #1;
        refresh();

        // Reset with every FIFO non-empty
        repeat (2) begin
            neg();
            check("rst_read", read, 0);
            check("rst_valid", out_valid, 0);
            check("rst_item", item_out, 0);
            check("rst_src", out_src, 0);
            pos();
        end
        reset     = 1'b0;
        out_ready = 1'b1;

        // All FIFOs non-empty, full throughput
        neg();
        check("t2_first_read", read, 4'b0001);
        pos();
        for (int k = 0; k < 5; k++) begin
            neg();
            check("t2_src", out_src, t2_src[k]);
            check("t2_item", item_out, t2_item[k]);
            check("t2_onehot", $onehot(read), 1);
            pos();
        end
        step(5);
        neg();
        check("t2_idle_read", read, 0);
        check("t2_idle_valid", out_valid, 0);
        pos();

        // Single FIFO back-to-back until its empty flag rises
        push(2, 8'h11);
        push(2, 8'h22);
        push(2, 8'h33);
        neg();
        check("t3_first_read", read, 4'b0100);
        pos();
        for (int k = 0; k < 3; k++) begin
            neg();
            check("t3_item", item_out, t3_item[k]);
            check("t3_src", out_src, 2);
            check("t3_read", read, t3_read[k]);
            pos();
        end
        step(1);

        // Stalled output holds item and priority
        out_ready = 1'b0;
        push(0, 8'h41);
        push(1, 8'h51);
        push(3, 8'h71);
        neg();
        check("t4_first_read", read, 4'b1000);
        pos();
        nreads = 0;
        repeat (5) begin
            neg();
            check("t4_item", item_out, 8'h71);
            check("t4_src", out_src, 3);
            check("t4_valid", out_valid, 1);
            nreads += (read != 0) ? 1 : 0;
            pos();
        end
        check("t4_stall_reads", nreads, CAP - 1);
        out_ready = 1'b1;
        step(1);
        neg();
        check("t4_item_a", item_out, 8'h41);
        check("t4_src_a", out_src, 0);
        pos();
        neg();
        check("t4_item_b", item_out, 8'h51);
        check("t4_src_b", out_src, 1);
        pos();
        step(2);

        // FIFOs 1 and 3 with ptr=2: grant 3, wrap, then 1
        push(1, 8'h81);
        push(3, 8'h93);
        neg();
        check("t5_read_3", read, 4'b1000);
        pos();
        neg();
        check("t5_src_3", out_src, 3);
        check("t5_item_3", item_out, 8'h93);
        check("t5_read_1", read, 4'b0010);
        pos();
        neg();
        check("t5_src_1", out_src, 1);
        check("t5_item_1", item_out, 8'h81);
        pos();
        step(2);

        // Reset while holding a stalled item
        out_ready = 1'b0;
        push(2, 8'hA5);
        push(3, 8'hB6);
        push(0, 8'hC7);
        neg();
        check("t6_read_2", read, 4'b0100);
        pos();
        neg();
        check("t6_held", item_out, 8'hA5);
        pos();
        step(1);
        reset = 1'b1;
        neg();
        check("t6_rst_read", read, 0);
        pos();
        reset     = 1'b0;
        out_ready = 1'b1;
        neg();
        check("t6_valid", out_valid, 0);
        check("t6_item", item_out, 0);
        check("t6_src", out_src, 0);
        check("t6_ptr0_read", read, 4'b0001);
        pos();
        neg();
        check("t6_item_c7", item_out, 8'hC7);
        pos();
        step(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
